sample_router: RTL and testbench
================================

SAMPLE_ROUTER -- requirements
Module: sample_router

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter BURST_LEN, default 1, words sent to one channel before switching (1..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port data_in  input  10  upstream sample.
REQ-006 SHALL have port data_valid  input  1  data_in is valid this cycle.
REQ-007 SHALL have port data_ready  output  1  router accepts data_in this cycle.
REQ-008 SHALL have port route_data  output  10  sample to the 1-to-2 demux in input.
REQ-009 SHALL have port route_sel  output  1  demux select: 0 = y path, 1 = x path.
REQ-010 SHALL have port route_valid  output  1  route_data/route_sel are valid.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the word this cycle.

Function
REQ-012 SHALL push data_in into the FIFO when data_valid && data_ready (accept).
REQ-013 SHALL drive data_ready = 1 exactly when FIFO occupancy < DEPTH; no push when full, even if a pop occurs in the same cycle.
REQ-014 SHALL drive route_valid = 1 exactly when occupancy > 0; route_data = FIFO head (first-word fall-through, zero added latency beyond the push cycle).
REQ-015 SHALL pop the head when route_valid && out_ready; out_ready while empty has no effect.
REQ-016 SHALL keep occupancy unchanged on simultaneous accept and pop; pointers wrap modulo DEPTH.
REQ-017 SHALL hold route_data and route_sel stable while route_valid && !out_ready.
REQ-018 SHALL implement channel FSM with states CH_Y (route_sel = 0) and CH_X (route_sel = 1).
REQ-019 SHALL keep a burst counter, incremented on each pop; when a pop occurs with counter == BURST_LEN-1, counter clears and FSM switches CH_Y<->CH_X on the same edge.
REQ-020 SHALL not change FSM state or burst counter in cycles without a pop.
REQ-021 SHALL treat a word entering an empty FIFO as visible at route_data the cycle after acceptance.

Reset
REQ-022 SHALL, when rst_n is low at a rising edge, clear occupancy and pointers, set FSM to CH_Y, clear burst counter.
REQ-023 SHALL drive during/after reset: data_ready = 1, route_valid = 0, route_sel = 0, route_data = 0.
REQ-024 SHALL discard in-flight FIFO contents on reset mid-operation; accept/pop in that cycle are ignored.

Configuration
REQ-025 SHALL support macro SAMPLE_ROUTER_ZERO_BLANK_EN: when defined, route_data SHALL be forced to 10'b0 whenever route_valid = 0.
REQ-026 SHALL, when SAMPLE_ROUTER_ZERO_BLANK_EN is undefined, leave route_data = FIFO storage at read pointer (don't-care, no forcing) while route_valid = 0.

Structure
REQ-027 SHALL place DATA_W = 10, channel-state enum (CH_Y, CH_X) and reset values in shared package sample_router_pkg.
REQ-028 SHALL implement storage/pointers/occupancy as sub-module sample_fifo (push, pop, full, empty, head); FSM and burst counter in sample_router.

Verification
REQ-029 SHALL cover: reset, then push 10'h001,10'h002,10'h003,10'h004 with out_ready=1, BURST_LEN=1 -> outputs 001/sel0, 002/sel1, 003/sel0, 004/sel1.
REQ-030 SHALL cover: BURST_LEN=2, push 5 words -> sel sequence 0,0,1,1,0.
REQ-031 SHALL cover: out_ready=0, push 5 words with DEPTH=4 -> 4 accepted, data_ready=0 on 5th, 5th held by upstream; then out_ready=1 -> words drain in order.
REQ-032 SHALL cover: full FIFO, data_valid=1 and out_ready=1 same cycle -> one pop, no push, occupancy 3, data_ready=1 next cycle.
REQ-033 SHALL cover: rst_n low for one cycle with 3 words queued and FSM in CH_X -> route_valid=0, route_sel=0, data_ready=1 next cycle.
REQ-034 SHALL cover: with SAMPLE_ROUTER_ZERO_BLANK_EN defined, drain to empty -> route_data=10'h000 while route_valid=0.

Source files
------------

// File: rtl/sample_router_pkg.sv
// sample_router_pkg -- shared definitions for the sample router slice.
//
// Contents:
//   DATA_W       sample width carried through the router (10 bits)
//   BURST_W      width of the burst counter (covers BURST_LEN up to 15)
//   ch_state_t   channel FSM encoding; the value doubles as the demux select
//   *_RST        reset values used by the FIFO and the channel FSM
//
// Optional build macro used by the top level: SAMPLE_ROUTER_ZERO_BLANK_EN.

package sample_router_pkg;

   localparam int DATA_W  = 10;
   localparam int BURST_W = 4;

   // Encoding is chosen so that the state bit is directly the demux select:
   // 0 = y path, 1 = x path.
   typedef enum logic {
      CH_Y = 1'b0,
      CH_X = 1'b1
   } ch_state_t;

   localparam ch_state_t           CH_RST    = CH_Y;
   localparam logic [BURST_W-1:0]  BURST_RST = '0;
   localparam logic [DATA_W-1:0]   DATA_RST  = '0;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo -- first-word fall-through FIFO used by sample_router.
//
// Ports:
//   clk      sole clock, rising edge
//   rst_n    synchronous active-low reset; clears pointers, occupancy and storage
//   push     write wr_data this cycle (ignored while full, even if popping)
//   pop      drop the head this cycle (ignored while empty)
//   wr_data  word to write
//   head     word at the read pointer (valid when !empty)
//   full     occupancy == DEPTH
//   empty    occupancy == 0
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.

module sample_fifo
   import sample_router_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              push_en;
   logic              pop_en;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   // A full FIFO never takes a word, even when a pop frees a slot on the
   // same edge; the upstream sees data_ready low and retries next cycle.
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         // Storage is cleared too so the head reads as zero out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= DATA_RST;
         end
      end else begin
         if (push_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sample_router.sv
// sample_router -- buffers upstream samples and steers them to a 1-to-2
// demux, alternating between the y and x paths every BURST_LEN words.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   data_in      upstream sample
//   data_valid   data_in valid this cycle
//   data_ready   router accepts data_in this cycle (FIFO not full)
//   route_data   FIFO head presented to the demux
//   route_sel    demux select: 0 = y path, 1 = x path
//   route_valid  route_data / route_sel are valid (FIFO not empty)
//   out_ready    downstream consumes the head this cycle
//
// Handshake: a word moves on an edge where valid && ready are both high on
// that side; valid-side data is held stable until the transfer completes.
//
// Build option: SAMPLE_ROUTER_ZERO_BLANK_EN forces route_data to zero while
// route_valid is low; otherwise route_data shows raw FIFO storage then.
//
// The channel FSM state is observable directly on route_sel.

module sample_router
   import sample_router_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int BURST_LEN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic [DATA_W-1:0] route_data,
   output logic              route_sel,
   output logic              route_valid,
   input  logic              out_ready
);

   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);

   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic              pop;

   ch_state_t          state_q;
   ch_state_t          state_d;
   logic [BURST_W-1:0] burst_q;
   logic [BURST_W-1:0] burst_d;

   sample_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (data_valid),
      .pop     (out_ready),
      .wr_data (data_in),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign data_ready  = !fifo_full;
   assign route_valid = !fifo_empty;
   assign pop         = route_valid && out_ready;
   assign route_sel   = state_q;

`ifdef SAMPLE_ROUTER_ZERO_BLANK_EN
   assign route_data = route_valid ? fifo_head : DATA_RST;
`else
   assign route_data = fifo_head;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CH_RST;
         burst_q <= BURST_RST;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
      end
   end

   // Channel and burst position only advance on a pop; the last word of a
   // burst switches the channel on the same edge that consumes it.
   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      if (pop) begin
         if (burst_q == BURST_LAST) begin
            burst_d = BURST_RST;
            state_d = (state_q == CH_Y) ? CH_X : CH_Y;
         end else begin
            burst_d = burst_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sample_router.sv
// tb_sample_router -- self-checking bench for sample_router.
// Two instances (BURST_LEN 1 and 2, DEPTH 4) share all inputs; their
// occupancy behaviour is identical, only the channel select differs.
// The reference model is a word queue plus a count of pops since reset;
// the expected select is (pops / BURST_LEN) mod 2.

module tb_sample_router;

   localparam int DEPTH = 4;
   localparam int W     = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] data_in;
   logic         data_valid;
   logic         out_ready;

   logic         dr1, rv1, sel1;
   logic [W-1:0] rd1;
   logic         dr2, rv2, sel2;
   logic [W-1:0] rd2;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [W-1:0] exp_q[$];
   int           pops = 0;
   bit           model_live = 1'b0;

   // words observed leaving instance 1 / select of each instance at that time
   logic [W-1:0] obs_data[$];
   logic         obs_sel1[$];
   logic         obs_sel2[$];

   sample_router #(.DEPTH(DEPTH), .BURST_LEN(1)) u_dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (dr1),
      .route_data  (rd1),
      .route_sel   (sel1),
      .route_valid (rv1),
      .out_ready   (out_ready)
   );

   sample_router #(.DEPTH(DEPTH), .BURST_LEN(2)) u_dut2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (dr2),
      .route_data  (rd2),
      .route_sel   (sel2),
      .route_valid (rv2),
      .out_ready   (out_ready)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   always @(posedge clk) begin
      bit acc;
      bit pp;
      if (!rst_n) begin
         exp_q.delete();
         pops       = 0;
         model_live = 1'b1;
      end else begin
         acc = data_valid && (exp_q.size() < DEPTH);
         pp  = out_ready && (exp_q.size() > 0);
         if (pp) begin
            void'(exp_q.pop_front());
            pops++;
         end
         if (acc) exp_q.push_back(data_in);
      end
   end

   // ---------------- compare process (opposite edge) ----------------
   always @(negedge clk) begin
      if (model_live) begin
         chk("data_ready1", {31'b0, dr1}, {31'b0, (exp_q.size() < DEPTH)});
         chk("data_ready2", {31'b0, dr2}, {31'b0, (exp_q.size() < DEPTH)});
         chk("route_valid1", {31'b0, rv1}, {31'b0, (exp_q.size() > 0)});
         chk("route_valid2", {31'b0, rv2}, {31'b0, (exp_q.size() > 0)});
         chk("route_sel1", {31'b0, sel1}, 32'((pops / 1) % 2));
         chk("route_sel2", {31'b0, sel2}, 32'((pops / 2) % 2));
         if (exp_q.size() > 0) begin
            chk("route_data1", {22'b0, rd1}, {22'b0, exp_q[0]});
            chk("route_data2", {22'b0, rd2}, {22'b0, exp_q[0]});
         end
`ifdef SAMPLE_ROUTER_ZERO_BLANK_EN
         else begin
            chk("blank_data1", {22'b0, rd1}, 32'h0);
            chk("blank_data2", {22'b0, rd2}, 32'h0);
         end
`endif
         if (rst_n && rv1 && out_ready) begin
            obs_data.push_back(rd1);
            obs_sel1.push_back(sel1);
            obs_sel2.push_back(sel2);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive_cycle(input logic r, input logic v, input logic [W-1:0] d, input logic o);
      rst_n      = r;
      data_valid = v;
      data_in    = d;
      out_ready  = o;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive_cycle(1'b0, 1'b0, '0, 1'b0);
      drive_cycle(1'b0, 1'b0, '0, 1'b0);
      chk("rst_data_ready", {31'b0, dr1}, 32'h1);
      chk("rst_route_valid", {31'b0, rv1}, 32'h0);
      chk("rst_route_sel", {31'b0, sel1}, 32'h0);
      chk("rst_route_data", {22'b0, rd1}, 32'h0);
      obs_data.delete();
      obs_sel1.delete();
      obs_sel2.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [W-1:0] ed [5];
      logic         es1 [5];
      logic         es2 [5];

      rst_n = 1'b0; data_valid = 1'b0; data_in = '0; out_ready = 1'b0;

      // --- alternating channel, BURST_LEN 1 and 2 ---
      do_reset();
      for (int i = 1; i <= 5; i++) drive_cycle(1'b1, 1'b1, W'(i), 1'b1);
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, '0, 1'b1);
      ed  = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
      es1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      es2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      chk("burst_count", 32'(obs_data.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < obs_data.size()) begin
            chk("burst_data", {22'b0, obs_data[i]}, {22'b0, ed[i]});
            chk("burst1_sel", {31'b0, obs_sel1[i]}, {31'b0, es1[i]});
            chk("burst2_sel", {31'b0, obs_sel2[i]}, {31'b0, es2[i]});
         end
      end

      // --- fill with out_ready low, 5th word held, pop while full ---
      do_reset();
      for (int i = 1; i <= 4; i++) drive_cycle(1'b1, 1'b1, W'(i), 1'b0);
      chk("full_ready", {31'b0, dr1}, 32'h0);
      chk("full_head", {22'b0, rd1}, 32'h001);
      drive_cycle(1'b1, 1'b1, 10'h005, 1'b0);
      drive_cycle(1'b1, 1'b1, 10'h005, 1'b0);
      chk("held_ready", {31'b0, dr1}, 32'h0);
      drive_cycle(1'b1, 1'b1, 10'h005, 1'b1);   // pop only, no push
      chk("pop_full_ready", {31'b0, dr1}, 32'h1);
      chk("pop_full_head", {22'b0, rd1}, 32'h002);
      drive_cycle(1'b1, 1'b1, 10'h005, 1'b0);   // 5th word accepted now
      chk("refill_ready", {31'b0, dr1}, 32'h0);
      for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, '0, 1'b1);
      chk("drain_valid", {31'b0, rv1}, 32'h0);
`ifdef SAMPLE_ROUTER_ZERO_BLANK_EN
      chk("drain_blank", {22'b0, rd1}, 32'h0);
`endif
      chk("drain_count", 32'(obs_data.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < obs_data.size()) chk("drain_order", {22'b0, obs_data[i]}, 32'(i + 1));
      end

      // --- reset mid-operation with FSM in CH_X ---
      do_reset();
      drive_cycle(1'b1, 1'b1, 10'h0AA, 1'b1);
      drive_cycle(1'b1, 1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, W'(10'h100 + i), 1'b0);
      chk("pre_rst_sel", {31'b0, sel1}, 32'h1);
      chk("pre_rst_valid", {31'b0, rv1}, 32'h1);
      drive_cycle(1'b0, 1'b1, 10'h3FF, 1'b1);   // accept/pop here are ignored
      chk("mid_rst_valid", {31'b0, rv1}, 32'h0);
      chk("mid_rst_sel", {31'b0, sel1}, 32'h0);
      chk("mid_rst_ready", {31'b0, dr1}, 32'h1);
      chk("mid_rst_data", {22'b0, rd1}, 32'h0);
      drive_cycle(1'b1, 1'b1, 10'h3AA, 1'b0);
      chk("post_rst_head", {22'b0, rd1}, 32'h3AA);
      chk("post_rst_sel", {31'b0, sel1}, 32'h0);

      // --- randomized traffic with occasional resets ---
      for (int n = 0; n < 1500; n++) begin
         drive_cycle(($urandom_range(0, 99) != 0),
                     ($urandom_range(0, 3) != 0),
                     W'($urandom_range(0, 1023)),
                     ($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, '0, 1'b1);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
